// File: rtl/seg_ascii_scroller.sv
// ASCII message buffer driving a multiplexed common-anode 7-segment display, static or marquee.
// Optional build macro: SEG_GHOST_BLANK_EN blanks the first 4 cycles of every digit slot.
module seg_ascii_scroller #(
  parameter int NUM_DIGITS      = 4,
  parameter int MSG_DEPTH       = 16,
  parameter int SCAN_DIV_BITS   = 18,
  parameter int SCROLL_DIV_BITS = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_valid,
  input  logic [7:0]                     wr_data,
  output logic                           wr_ready,
  input  logic                           clr,
  input  logic                           scroll_en,
  output logic [$clog2(MSG_DEPTH+1)-1:0] msg_len,
  output logic [NUM_DIGITS-1:0]          digit_sel,
  output logic [7:0]                     seg_out
);
  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int PW = $clog2(NUM_DIGITS + MSG_DEPTH + 1);
  localparam int DW = $clog2(NUM_DIGITS);

  logic [7:0]                 r_msg [MSG_DEPTH];
  logic [LW-1:0]              r_len;
  logic                       r_wr_ready;
  logic [PW-1:0]              r_pos;
  logic [SCAN_DIV_BITS-1:0]   r_scan_cnt;
  logic [DW-1:0]              r_digit_idx;
  logic [SCROLL_DIV_BITS-1:0] r_scroll_cnt;
  logic                       r_scroll_d;
  logic [7:0]                 r_char1;
  logic                       r_blank1;
  logic [NUM_DIGITS-1:0]      r_sel1;
  logic [NUM_DIGITS-1:0]      r_digit_sel;
  logic [7:0]                 r_seg;

  logic                       w_accept;
  logic [LW-1:0]              w_len_next;
  logic                       w_scroll_rise;
  logic                       w_scroll_wrap;
  logic [31:0]                w_pos_inc;
  logic [PW-1:0]              w_pos_next;
  logic [31:0]                w_vidx;
  logic                       w_blank;
  logic [AW-1:0]              w_rd_addr;
  logic                       w_ghost;

  function automatic logic [7:0] f_decode(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      8'h20: f_decode = 8'hFF;  8'h2E: f_decode = 8'hFD;  8'h2D: f_decode = 8'hF7;
      8'h30: f_decode = 8'h0A;  8'h31: f_decode = 8'h6F;  8'h32: f_decode = 8'h32;
      8'h33: f_decode = 8'h23;  8'h34: f_decode = 8'h47;  8'h35: f_decode = 8'h83;
      8'h36: f_decode = 8'h82;  8'h37: f_decode = 8'h2F;  8'h38: f_decode = 8'h02;
      8'h39: f_decode = 8'h03;
      8'h41: f_decode = 8'h06;  8'h42: f_decode = 8'hC2;  8'h43: f_decode = 8'h9A;
      8'h44: f_decode = 8'h62;  8'h45: f_decode = 8'h92;  8'h46: f_decode = 8'h96;
      8'h47: f_decode = 8'h8A;  8'h48: f_decode = 8'h46;  8'h49: f_decode = 8'hDE;
      8'h4A: f_decode = 8'h6A;  8'h4B: f_decode = 8'h86;  8'h4C: f_decode = 8'hDA;
      8'h4D: f_decode = 8'hAE;  8'h4E: f_decode = 8'hE6;  8'h4F: f_decode = 8'hE2;
      8'h50: f_decode = 8'h16;  8'h51: f_decode = 8'h07;  8'h52: f_decode = 8'hF6;
      8'h53: f_decode = 8'h83;  8'h54: f_decode = 8'hD2;  8'h55: f_decode = 8'hEA;
      8'h56: f_decode = 8'h4A;  8'h57: f_decode = 8'h5B;  8'h58: f_decode = 8'h46;
      8'h59: f_decode = 8'h43;  8'h5A: f_decode = 8'h32;
      default: f_decode = 8'hF7;
    endcase
  endfunction

  // clr beats a same-cycle write, so the byte is dropped.
  assign w_accept   = wr_valid && r_wr_ready && !clr;
  assign w_len_next = clr ? '0 : (w_accept ? r_len + LW'(1) : r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_wr_ready <= 1'b1;
    end else begin
      r_len      <= w_len_next;
      r_wr_ready <= (32'(w_len_next) < 32'(MSG_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_msg[r_len[AW-1:0]] <= wr_data;
  end

  assign w_scroll_rise = scroll_en && !r_scroll_d;
  assign w_scroll_wrap = scroll_en && (&r_scroll_cnt);
  assign w_pos_inc     = 32'(r_pos) + 32'd1;

  always_comb begin
    w_pos_next = r_pos;
    if (w_scroll_rise)      w_pos_next = '0;
    else if (!scroll_en)    w_pos_next = PW'(NUM_DIGITS);
    else if (clr)           w_pos_next = '0;
    else if (w_scroll_wrap) w_pos_next = (w_pos_inc >= 32'(NUM_DIGITS) + 32'(r_len)) ? '0 : PW'(w_pos_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scroll_d   <= 1'b0;
      r_pos        <= '0;
      r_scroll_cnt <= '0;
      r_scan_cnt   <= '0;
      r_digit_idx  <= '0;
    end else begin
      r_scroll_d   <= scroll_en;
      r_pos        <= w_pos_next;
      r_scroll_cnt <= (w_scroll_rise || !scroll_en) ? '0 : r_scroll_cnt + SCROLL_DIV_BITS'(1);
      r_scan_cnt   <= r_scan_cnt + SCAN_DIV_BITS'(1);
      if (&r_scan_cnt)
        r_digit_idx <= (r_digit_idx == DW'(NUM_DIGITS - 1)) ? '0 : r_digit_idx + DW'(1);
    end
  end

  // Digit k shows window slot NUM_DIGITS-1-k, i.e. virtual index pos+NUM_DIGITS-1-k.
  assign w_vidx    = 32'(r_pos) + 32'(NUM_DIGITS - 1) - 32'(r_digit_idx);
  assign w_blank   = (w_vidx < 32'(NUM_DIGITS)) || ((w_vidx - 32'(NUM_DIGITS)) >= 32'(r_len));
  assign w_rd_addr = w_blank ? '0 : AW'(w_vidx - 32'(NUM_DIGITS));

  always_ff @(posedge clk) begin
    r_char1 <= r_msg[w_rd_addr];
  end

`ifdef SEG_GHOST_BLANK_EN
  logic r_ghost1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ghost1 <= 1'b1;
    else        r_ghost1 <= (32'(r_scan_cnt) < 32'd4);
  end
  assign w_ghost = r_ghost1;
`else
  assign w_ghost = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank1    <= 1'b1;
      r_sel1      <= '0;
      r_digit_sel <= '0;
      r_seg       <= 8'hFF;
    end else begin
      r_blank1    <= w_blank;
      r_sel1      <= NUM_DIGITS'(1) << r_digit_idx;
      r_digit_sel <= w_ghost ? '0 : r_sel1;
      r_seg       <= (r_blank1 || w_ghost) ? 8'hFF : f_decode(r_char1);
    end
  end

  assign wr_ready  = r_wr_ready;
  assign msg_len   = r_len;
  assign digit_sel = r_digit_sel;
  assign seg_out   = r_seg;
endmodule
